cache_flush_ctrl: RTL and testbench



---
 rtl/cache_flush_ctrl_if.sv | 20 ++
 rtl/cache_flush_ctrl.sv | 124 ++++++++++++
 tb/tb_cache_flush_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_flush_ctrl_if.sv
// cache_flush_ctrl_if: AXI-Lite write-only manager channels used for line writeback
interface cache_flush_ctrl_if;
  logic [31:0] axil_awaddr_mng;
  logic        axil_awvalid_mng;
  logic        axil_awready_mng;
  logic [31:0] axil_wdata_mng;
  logic        axil_wvalid_mng;
  logic        axil_wready_mng;
  logic [1:0]  axil_bresp_mng;
  logic        axil_bvalid_mng;
  logic        axil_bready_mng;
  modport master (
    output axil_awaddr_mng, axil_awvalid_mng, axil_wdata_mng, axil_wvalid_mng, axil_bready_mng,
    input  axil_awready_mng, axil_wready_mng, axil_bresp_mng, axil_bvalid_mng
  );
  modport slave (
    input  axil_awaddr_mng, axil_awvalid_mng, axil_wdata_mng, axil_wvalid_mng, axil_bready_mng,
    output axil_awready_mng, axil_wready_mng, axil_bresp_mng, axil_bvalid_mng
  );
endinterface

// File: rtl/cache_flush_ctrl.sv
// cache_flush_ctrl: walks every cache set, writes back dirty lines, then invalidates the set
module cache_flush_ctrl #(
  parameter int INDEX    = 12,
  parameter int TAG_SIZE = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done,
  output logic                     flush_err,
  output logic [INDEX-1:0]         ram_addr,
  output logic                     ram_re,
  input  logic [1:0]               valid_out,
  input  logic [1:0]               dirty_out,
  input  logic [1:0][TAG_SIZE-1:0] tag_out,
  input  logic [1:0][31:0]         data_out,
  output logic [1:0]               meta_we,
  output logic                     lru_we,
  cache_flush_ctrl_if.master       axi
);
  typedef enum logic [2:0] {IDLE, RD, CHK, WB_REQ, WB_RESP, CLR, DONE} state_t;
  state_t              state;
  logic [INDEX-1:0]    set_idx;
  logic                way;
  logic                pend1;
  logic [TAG_SIZE-1:0] tag1_q;
  logic [31:0]         data1_q;
  logic [1:0]          vd;
  assign vd = valid_out & dirty_out;
  assign ram_addr = set_idx;
  // Flush sequencer; every output is a register updated on the transition into the state that needs it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      set_idx              <= '0;
      way                  <= 1'b0;
      pend1                <= 1'b0;
      tag1_q               <= '0;
      data1_q              <= '0;
      flush_busy           <= 1'b0;
      flush_done           <= 1'b0;
      flush_err            <= 1'b0;
      ram_re               <= 1'b0;
      meta_we              <= '0;
      lru_we               <= 1'b0;
      axi.axil_awaddr_mng  <= '0;
      axi.axil_awvalid_mng <= 1'b0;
      axi.axil_wdata_mng   <= '0;
      axi.axil_wvalid_mng  <= 1'b0;
      axi.axil_bready_mng  <= 1'b0;
    end else begin
      ram_re     <= 1'b0;
      meta_we    <= '0;
      lru_we     <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: if (flush_req) begin
          set_idx    <= '0;
          way        <= 1'b0;
          flush_err  <= 1'b0;
          flush_busy <= 1'b1;
          ram_re     <= 1'b1;
          state      <= RD;
        end
        RD: state <= CHK;
        CHK: begin
          pend1   <= vd[1];
          tag1_q  <= tag_out[1];
          data1_q <= data_out[1];
          if (|vd) begin
            way                  <= ~vd[0];
            axi.axil_awaddr_mng  <= {tag_out[~vd[0]], set_idx, 2'b00};
            axi.axil_wdata_mng   <= data_out[~vd[0]];
            axi.axil_awvalid_mng <= 1'b1;
            axi.axil_wvalid_mng  <= 1'b1;
            state                <= WB_REQ;
          end else begin
            meta_we <= 2'b11;
            lru_we  <= 1'b1;
            state   <= CLR;
          end
        end
        WB_REQ: begin
          if (axi.axil_awvalid_mng && axi.axil_awready_mng) axi.axil_awvalid_mng <= 1'b0;
          if (axi.axil_wvalid_mng && axi.axil_wready_mng) axi.axil_wvalid_mng <= 1'b0;
          if ((!axi.axil_awvalid_mng || axi.axil_awready_mng) && (!axi.axil_wvalid_mng || axi.axil_wready_mng)) begin
            axi.axil_bready_mng <= 1'b1;
            state               <= WB_RESP;
          end
        end
        WB_RESP: if (axi.axil_bvalid_mng) begin
          axi.axil_bready_mng <= 1'b0;
          if (axi.axil_bresp_mng != 2'b00) flush_err <= 1'b1;
          if (!way && pend1) begin
            way                  <= 1'b1;
            axi.axil_awaddr_mng  <= {tag1_q, set_idx, 2'b00};
            axi.axil_wdata_mng   <= data1_q;
            axi.axil_awvalid_mng <= 1'b1;
            axi.axil_wvalid_mng  <= 1'b1;
            state                <= WB_REQ;
          end else begin
            meta_we <= 2'b11;
            lru_we  <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: if (set_idx == '1) begin
          set_idx    <= '0;
          flush_busy <= 1'b0;
          flush_done <= 1'b1;
          state      <= DONE;
        end else begin
          set_idx <= set_idx + INDEX'(1);
          way     <= 1'b0;
          ram_re  <= 1'b1;
          state   <= RD;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_flush_ctrl.sv
// tb_cache_flush_ctrl: table vectors, corner sequences and random flushes against a set-walk model
module tb_cache_flush_ctrl;
  localparam int IX = 3;
  localparam int TS = 27;
  localparam int SETS = 8;
  logic clk = 1'b0;
  logic rst_n, flush_req;
  logic flush_busy, flush_done, flush_err, ram_re, lru_we;
  logic [IX-1:0] ram_addr;
  logic [1:0] valid_out, dirty_out, meta_we;
  logic [1:0][TS-1:0] tag_out;
  logic [1:0][31:0] data_out;
  cache_flush_ctrl_if axi();
  cache_flush_ctrl #(.INDEX(IX), .TAG_SIZE(TS)) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .flush_err(flush_err), .ram_addr(ram_addr), .ram_re(ram_re),
    .valid_out(valid_out), .dirty_out(dirty_out), .tag_out(tag_out), .data_out(data_out),
    .meta_we(meta_we), .lru_we(lru_we), .axi(axi)
  );
  always #5 clk = ~clk;
  logic [1:0]  mem_v [SETS];
  logic [1:0]  mem_d [SETS];
  logic [TS-1:0] mem_tag [SETS][2];
  logic [31:0] mem_dat [SETS][2];
  int lru_cnt [SETS];
  int clr_cnt, aw_tot, w_tot, b_iss, awd, wd, bd, aw_cyc, w_cyc, first_rd;
  int errors = 0, checks = 0;
  bit rnd, exp_err_acc;
  logic [31:0] aw_q[$], w_q[$], exp_a[$], exp_w[$];
  logic [1:0] resp_q[$];
  typedef struct {
    int set; logic [1:0] mask; logic [TS-1:0] t0, t1; logic [31:0] d0, d1;
    int awd, wd, bd; logic [1:0] br0, br1;
    int exp_busy; logic [31:0] exp_addr0; logic exp_err; int exp_aw, exp_w;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  // memory-side and AXI-Lite subordinate model: records at posedge, drives inputs at negedge
  initial begin
    bit aw_hs, w_hs, b_hs, rd_pend, aw_ok, w_ok;
    int rd_a, awc, wc, bc, pend;
    logic [31:0] p_aw, p_w;
    aw_ok = 0; w_ok = 0; rd_pend = 0; rd_a = 0; awc = 0; wc = 0; bc = 0; b_hs = 0;
    p_aw = 0; p_w = 0;
    forever begin
      @(posedge clk);
      aw_hs = axi.axil_awvalid_mng && axi.axil_awready_mng;
      w_hs  = axi.axil_wvalid_mng && axi.axil_wready_mng;
      b_hs  = axi.axil_bvalid_mng && axi.axil_bready_mng;
      if (aw_ok) chk("aw_hold", {31'd0, axi.axil_awvalid_mng, axi.axil_awaddr_mng}, {31'd0, 1'b1, p_aw});
      if (w_ok) chk("w_hold", {31'd0, axi.axil_wvalid_mng, axi.axil_wdata_mng}, {31'd0, 1'b1, p_w});
      aw_ok = rst_n && axi.axil_awvalid_mng && !aw_hs;
      w_ok  = rst_n && axi.axil_wvalid_mng && !w_hs;
      p_aw = axi.axil_awaddr_mng;
      p_w  = axi.axil_wdata_mng;
      if (aw_hs) begin aw_q.push_back(axi.axil_awaddr_mng); aw_tot++; end
      if (w_hs) begin w_q.push_back(axi.axil_wdata_mng); w_tot++; end
      if (axi.axil_awvalid_mng) aw_cyc++;
      if (axi.axil_wvalid_mng) w_cyc++;
      for (int w = 0; w < 2; w++) if (meta_we[w]) begin
        mem_v[ram_addr][w] = 1'b0;
        mem_d[ram_addr][w] = 1'b0;
      end
      if (lru_we) lru_cnt[ram_addr]++;
      if (meta_we == 2'b11) clr_cnt++;
      if (ram_re) begin
        rd_pend = 1;
        rd_a = int'(ram_addr);
        if (first_rd < 0) first_rd = int'(ram_addr);
      end
      @(negedge clk);
      if (rd_pend) begin
        valid_out = mem_v[rd_a];
        dirty_out = mem_d[rd_a];
        for (int w = 0; w < 2; w++) begin
          tag_out[w]  = mem_tag[rd_a][w];
          data_out[w] = mem_dat[rd_a][w];
        end
      end else begin
        valid_out = 2'($urandom);
        dirty_out = 2'($urandom);
        for (int w = 0; w < 2; w++) begin
          tag_out[w]  = TS'($urandom);
          data_out[w] = $urandom;
        end
      end
      rd_pend = 0;
      if (aw_hs && rnd) awd = $urandom_range(0, 3);
      if (w_hs && rnd) wd = $urandom_range(0, 3);
      axi.axil_awready_mng = axi.axil_awvalid_mng && (awc >= awd);
      awc = axi.axil_awvalid_mng && !aw_hs ? awc + 1 : 0;
      axi.axil_wready_mng = axi.axil_wvalid_mng && (wc >= wd);
      wc = axi.axil_wvalid_mng && !w_hs ? wc + 1 : 0;
      if (b_hs) axi.axil_bvalid_mng = 1'b0;
      pend = (aw_tot < w_tot ? aw_tot : w_tot) - b_iss;
      if (!axi.axil_bvalid_mng && pend > 0) begin
        if (bc >= bd) begin
          axi.axil_bvalid_mng = 1'b1;
          axi.axil_bresp_mng = resp_q.size() > 0 ? resp_q.pop_front() :
                               (rnd && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
          if (axi.axil_bresp_mng != 2'b00) exp_err_acc = 1'b1;
          b_iss++;
          bc = 0;
          if (rnd) bd = $urandom_range(0, 3);
        end else bc++;
      end
    end
  end
  task automatic slave_clear();
    axi.axil_bvalid_mng = 1'b0;
    aw_tot = 0; w_tot = 0; b_iss = 0;
    aw_q.delete(); w_q.delete(); resp_q.delete();
  endtask
  task automatic prep(input bit clean_valid);
    for (int s = 0; s < SETS; s++) begin
      mem_v[s] = clean_valid ? 2'($urandom) : 2'b00;
      mem_d[s] = 2'b00;
      lru_cnt[s] = 0;
      for (int w = 0; w < 2; w++) begin
        mem_tag[s][w] = TS'($urandom);
        mem_dat[s][w] = $urandom;
      end
    end
    clr_cnt = 0; aw_cyc = 0; w_cyc = 0; first_rd = -1; exp_err_acc = 1'b0;
    aw_q.delete(); w_q.delete();
  endtask
  // reference: every valid+dirty way, set-major then way-minor, written to {tag, set, 00}
  task automatic build_exp();
    exp_a.delete(); exp_w.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < 2; w++)
        if (mem_v[s][w] && mem_d[s][w]) begin
          exp_a.push_back({mem_tag[s][w], IX'(s), 2'b00});
          exp_w.push_back(mem_dat[s][w]);
        end
  endtask
  task automatic check_result(input string tag);
    int bad_v, bad_l;
    chk({tag, "_nwr_aw"}, 64'(aw_q.size()), 64'(exp_a.size()));
    chk({tag, "_nwr_w"}, 64'(w_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_a.size(); i++) begin
      chk({tag, "_awaddr"}, i < aw_q.size() ? 64'(aw_q[i]) : 64'hdead, 64'(exp_a[i]));
      chk({tag, "_wdata"}, i < w_q.size() ? 64'(w_q[i]) : 64'hdead, 64'(exp_w[i]));
    end
    bad_v = 0; bad_l = 0;
    for (int s = 0; s < SETS; s++) begin
      if (mem_v[s] != 2'b00) bad_v++;
      if (lru_cnt[s] != 1) bad_l++;
    end
    chk({tag, "_left_valid"}, 64'(bad_v), 64'd0);
    chk({tag, "_lru_bad"}, 64'(bad_l), 64'd0);
    chk({tag, "_err"}, 64'(flush_err), 64'(exp_err_acc));
  endtask
  task automatic run_flush(input int hold, output int busy, output int done_at, output int done_cnt);
    busy = 0; done_at = 0; done_cnt = 0;
    @(negedge clk);
    flush_req = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c >= hold) flush_req = 1'b0;
      if (flush_busy) busy++;
      if (flush_done) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (done_at != 0 && c > done_at + 3) break;
    end
  endtask
  initial begin
    int busy, done_at, done_cnt, c;
    rst_n = 1'b0; flush_req = 1'b0; rnd = 1'b0; awd = 0; wd = 0; bd = 0;
    axi.axil_awready_mng = 1'b0; axi.axil_wready_mng = 1'b0;
    axi.axil_bvalid_mng = 1'b0; axi.axil_bresp_mng = 2'b00;
    valid_out = '0; dirty_out = '0; tag_out = '0; data_out = '0;
    slave_clear();
    prep(1'b0);
    vt[0] = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 24, 32'h0, 1'b0, 0, 0};
    vt[1] = '{5, 2'b10, 27'h0, 27'h2A, 32'h0, 32'hDEADBEEF, 0, 0, 0, 2'b00, 2'b00, 26, 32'h554, 1'b0, 1, 1};
    vt[2] = '{5, 2'b10, 27'h0, 27'h2A, 32'h0, 32'hDEADBEEF, 3, 0, 0, 2'b00, 2'b00, 29, 32'h554, 1'b0, 4, 1};
    vt[3] = '{2, 2'b11, 27'h11, 27'h22, 32'h11112222, 32'h33334444, 0, 0, 0, 2'b10, 2'b00, 28, 32'h228, 1'b1, 2, 2};
    vt[4] = '{7, 2'b01, 27'h7FFFFFF, 27'h1, 32'hA5A55A5A, 32'h0, 0, 2, 3, 2'b00, 2'b00, 31, 32'hFFFFFFFC, 1'b0, 1, 3};
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {51'd0, flush_busy, flush_done, flush_err, ram_re, ram_addr, meta_we, lru_we,
        axi.axil_awvalid_mng, axi.axil_wvalid_mng, axi.axil_bready_mng}, 64'd0);
    chk("rst_data", {axi.axil_awaddr_mng, axi.axil_wdata_mng}, 64'd0);
    rst_n = 1'b1;
    foreach (vt[i]) begin
      prep(1'b1);
      mem_v[vt[i].set] = vt[i].mask;
      mem_d[vt[i].set] = vt[i].mask;
      mem_tag[vt[i].set][0] = vt[i].t0; mem_tag[vt[i].set][1] = vt[i].t1;
      mem_dat[vt[i].set][0] = vt[i].d0; mem_dat[vt[i].set][1] = vt[i].d1;
      awd = vt[i].awd; wd = vt[i].wd; bd = vt[i].bd;
      resp_q.delete();
      if (vt[i].mask[0]) resp_q.push_back(vt[i].br0);
      if (vt[i].mask[1]) resp_q.push_back(vt[i].br1);
      build_exp();
      run_flush(1, busy, done_at, done_cnt);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].exp_busy));
      chk($sformatf("v%0d_done_at", i), 64'(done_at), 64'(vt[i].exp_busy + 1));
      chk($sformatf("v%0d_done_cnt", i), 64'(done_cnt), 64'd1);
      chk($sformatf("v%0d_first_addr", i), aw_q.size() > 0 ? 64'(aw_q[0]) : 64'h0, 64'(vt[i].exp_addr0));
      chk($sformatf("v%0d_err_tbl", i), 64'(flush_err), 64'(vt[i].exp_err));
      chk($sformatf("v%0d_aw_cyc", i), 64'(aw_cyc), 64'(vt[i].exp_aw));
      chk($sformatf("v%0d_w_cyc", i), 64'(w_cyc), 64'(vt[i].exp_w));
      chk($sformatf("v%0d_clr_cnt", i), 64'(clr_cnt), 64'(SETS));
      check_result($sformatf("v%0d", i));
    end
    awd = 0; wd = 0; bd = 0;
    prep(1'b1);
    build_exp();
    run_flush(5, busy, done_at, done_cnt);
    chk("late_req_busy", 64'(busy), 64'd24);
    chk("late_req_done_cnt", 64'(done_cnt), 64'd1);
    prep(1'b1);
    @(negedge clk);
    flush_req = 1'b1;
    c = 0;
    while (!flush_done && c < 200) begin @(negedge clk); c++; end
    chk("held_done_seen", 64'(flush_done), 64'd1);
    @(negedge clk);
    chk("held_idle_gap", 64'(flush_busy), 64'd0);
    @(negedge clk);
    chk("held_restart", 64'(flush_busy), 64'd1);
    flush_req = 1'b0;
    c = 0;
    while (!flush_done && c < 200) begin @(negedge clk); c++; end
    chk("held_second_done", 64'(flush_done), 64'd1);
    repeat (2) @(negedge clk);
    prep(1'b1);
    mem_v[3] = 2'b01; mem_d[3] = 2'b01;
    bd = 20;
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    c = 0;
    while (!axi.axil_bready_mng && c < 200) begin @(negedge clk); c++; end
    chk("rr_in_resp", 64'(axi.axil_bready_mng), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 slave_clear();
    @(negedge clk);
    chk("rr_ctrl", {51'd0, flush_busy, flush_done, flush_err, ram_re, ram_addr, meta_we, lru_we,
        axi.axil_awvalid_mng, axi.axil_wvalid_mng, axi.axil_bready_mng}, 64'd0);
    chk("rr_data", {axi.axil_awaddr_mng, axi.axil_wdata_mng}, 64'd0);
    rst_n = 1'b1;
    bd = 0;
    for (int s = 0; s < SETS; s++) lru_cnt[s] = 0;
    first_rd = -1; exp_err_acc = 1'b0;
    build_exp();
    run_flush(1, busy, done_at, done_cnt);
    chk("rr_first_set", 64'(first_rd), 64'd0);
    chk("rr_busy", 64'(busy), 64'd26);
    check_result("rr");
    rnd = 1'b1;
    awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
    for (int it = 0; it < 20; it++) begin
      prep(1'b1);
      for (int s = 0; s < SETS; s++) mem_d[s] = 2'($urandom);
      build_exp();
      run_flush(1, busy, done_at, done_cnt);
      chk($sformatf("r%0d_done_cnt", it), 64'(done_cnt), 64'd1);
      chk($sformatf("r%0d_busy_min", it), 64'(busy >= 24 + 2 * exp_a.size()), 64'd1);
      check_result($sformatf("r%0d", it));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
